// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: decode inputs, memory handshake and datapath controls of the multicycle controller
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       is_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
    logic       instr_done;
    logic       trap;

    modport master (
        input  op, funct3, funct7, is_zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src, instr_done, trap
    );

    modport slave (
        output op, funct3, funct7, is_zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src, instr_done, trap
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a shared-memory multicycle RV32I datapath, with wait timeout and trap
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 16
) (
    input logic clk,
    input logic rst,
    multicycle_ctrl_if.master bus
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        logic [1:0] imm_src;
        logic       instr_done;
        logic       trap;
    } ctl_t;

    state_t        state, next, dec_next;
    logic [CW-1:0] cnt;
    logic          mem_st, timeout, f3_ok;
    logic [1:0]    imm;
    logic [2:0]    exec_alu;
    ctl_t          c, o;

    assign mem_st  = state inside {FETCH, MEMREAD, MEMWRITE};
    // mem_ready on the limit cycle still completes the access
    assign timeout = mem_st && !bus.mem_ready && cnt == CW'(WAIT_LIMIT);
    assign f3_ok   = bus.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
    assign imm     = bus.op == OP_SW ? 2'b01 : bus.op == OP_B ? 2'b10 : bus.op == OP_J ? 2'b11 : 2'b00;
    assign exec_alu = bus.funct3 == 3'b000 ? ((state == EXECR && bus.funct7) ? SUB : ADD) :
                      bus.funct3 == 3'b010 ? SLT :
                      bus.funct3 == 3'b110 ? OR : AND;
    assign dec_next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                      bus.op == OP_R ? (f3_ok ? EXECR : TRAP) :
                      bus.op == OP_I ? (f3_ok ? EXECI : TRAP) :
                      (bus.op == OP_B && bus.funct3 == 3'b000) ? BEQ :
                      bus.op == OP_J ? JAL : TRAP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= next;
            cnt   <= (mem_st && !bus.mem_ready && !timeout) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        next = state;
        case (state)
            FETCH:    next = timeout ? TRAP : bus.mem_ready ? DECODE : FETCH;
            DECODE:   next = dec_next;
            MEMADR:   next = bus.op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  next = timeout ? TRAP : bus.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next = timeout ? TRAP : bus.mem_ready ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ: next = FETCH;
            EXECR, EXECI, JAL: next = ALUWB;
            default:  next = TRAP;
        endcase
    end

    always_comb begin
        c = '0;
        c.imm_src = imm;
        case (state)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.ir_write   = bus.mem_ready;
                c.pc_write   = bus.mem_ready;
            end
            DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.mem_write  = 1'b1;
                c.adr_src    = 1'b1;
                c.instr_done = bus.mem_ready;
            end
            EXECR, EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = state == EXECI ? 2'b01 : 2'b00;
                c.alu_ctrl  = exec_alu;
            end
            ALUWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = 2'b10;
                c.alu_ctrl   = SUB;
                c.pc_write   = bus.is_zero;
                c.instr_done = 1'b1;
            end
            JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            default: begin
                c.imm_src = 2'b00;
                c.trap    = 1'b1;
            end
        endcase
    end

    // outputs are held low for as long as reset is asserted
    assign o = rst ? c : '0;

    assign bus.mem_req    = o.mem_req;
    assign bus.mem_write  = o.mem_write;
    assign bus.adr_src    = o.adr_src;
    assign bus.ir_write   = o.ir_write;
    assign bus.pc_write   = o.pc_write;
    assign bus.reg_write  = o.reg_write;
    assign bus.alu_src_a  = o.alu_src_a;
    assign bus.alu_src_b  = o.alu_src_b;
    assign bus.result_src = o.result_src;
    assign bus.alu_ctrl   = o.alu_ctrl;
    assign bus.imm_src    = o.imm_src;
    assign bus.instr_done = o.instr_done;
    assign bus.trap       = o.trap;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style FSM controller that sequences a multicycle RV32I datapath, which shares one unified instruction/data memory. It replaces the single-cycle controller when the core moves to a shared-memory, multicycle datapath. It decodes op/funct3/funct7 and steps each instruction through fetch, decode, execute, memory and writeback. It stalls on a memory ready handshake and traps on illegal encodings or a memory timeout.

Parameters:
WAIT_LIMIT, 16, max cycles a memory request may wait for mem_ready before trapping (>=1).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
op  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7  input  1  instr[30]
is_zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access requested
mem_write  output  1  access is a store
adr_src  output  1  0 = PC, 1 = ALUOut as memory address
ir_write  output  1  load instruction register (and OldPC)
pc_write  output  1  load PC from result mux
reg_write  output  1  register file write enable
alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4
result_src  output  2  00 ALUOut, 01 read data, 10 ALU result
alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  output  2  00 I, 01 S, 10 B, 11 J (decoded from op, valid in every state)
instr_done  output  1  one-cycle pulse on the final cycle of each retired instruction
trap  output  1  sticky illegal/timeout flag

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Reset: state=FETCH, wait counter=0, trap=0. While rst=0, every output is forced to 0.
- Any output not listed for a state is 0. The alu_ctrl default is add.
- FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - On mem_ready go to DECODE; otherwise stay.
- DECODE: src_a=01, src_b=01, add (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 with funct3=000 -> BEQ.
  - 1101111 -> JAL.
  - Anything else -> TRAP.
  - Also -> TRAP for unsupported funct3 in R/I types. Supported funct3: 000, 010, 110, 111.
- MEMADR: src_a=10, src_b=01, add. Next state is MEMREAD for load, MEMWRITE for store.
- MEMREAD: mem_req=1, adr_src=1. Go to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next state FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. instr_done=mem_ready. Go to FETCH on mem_ready.
- EXECR / EXECI: src_a=10, src_b=00 (R) or 01 (I). Next state ALUWB.
  - funct3 000 gives add, or sub when R-type and funct7=1. I-type ignores funct7.
  - funct3 010 gives slt, 110 gives or, 111 gives and.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next state FETCH.
- BEQ: src_a=10, src_b=00, sub, result_src=00, pc_write=is_zero, instr_done=1. Next state FETCH.
- JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1. Next state ALUWB (rd=PC+4).
- Zero-wait latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Each mem_ready wait adds 1 cycle.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on leaving a memory state.
  - When the counter reaches WAIT_LIMIT with mem_ready still 0 -> TRAP.
  - mem_ready on the limit cycle wins (no trap).
- TRAP: trap=1, all other outputs 0. Absorbing until reset.
- mem_ready outside a memory state is ignored.
- Async reset mid-instruction (including mid-wait) aborts immediately. The first post-reset cycle is FETCH.

Test Plan:
- Reset sequence: rst=0 for 3 cycles then 1, mem_ready=1. Required: all outputs 0 during reset; cycle 1 after release has mem_req=1, ir_write=1, pc_write=1, src_b=10.
- R-type sub (op=0110011, funct3=000, funct7=1), mem_ready=1. Required: states FETCH, DECODE, EXECR (alu_ctrl=001), ALUWB (reg_write=1, instr_done=1); 4 cycles.
- lw with 2 wait cycles in MEMREAD. Required: mem_req=1, adr_src=1 held 3 cycles; MEMWB reg_write=1, result_src=01; total 7 cycles.
- beq (op=1100011, funct3=000) with is_zero=1, then again with is_zero=0. Required: pc_write=1 for the first and 0 for the second in the BEQ cycle; instr_done=1 both times; 3 cycles each.
- Illegal op=1111111 in DECODE. Required: TRAP next cycle, trap=1 sticky for 20 cycles; cleared only by rst=0.
- FETCH with mem_ready=0 for 16 cycles (WAIT_LIMIT=16). Required: trap=1 after the limit. The same test with mem_ready=1 on the limit cycle advances to DECODE with no trap.
